// File: rtl/cpc_bus_cycle_decoder.sv
// Z80 bus-cycle classifier with glitch-filtered RAM/ROM config-write strobes for the banking stage.
// Latency: 1 clk input register; cfg strobes pulse 1 clk after the FSM enters IOHOLD.
// Backpressure: none; the Z80 bus cannot be stalled, so every qualified IO write pulses at most once.
module cpc_bus_cycle_decoder #(
    parameter int FILTER_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mreq_b,
    input  logic             iorq_b,
    input  logic             rd_b,
    input  logic             wr_b,
    input  logic             m1_b,
    input  logic             rfsh_b,
    input  logic             adr15,
    input  logic             adr8,
    input  logic [7:0]       data,
    output logic             mem_rd_cyc,
    output logic             mem_wr_cyc,
    output logic             ram_cfg_we,
    output logic             rom_cfg_we,
    output logic [7:0]       cfg_data,
    output logic             cfg_lo,
    output logic [CNT_W-1:0] cyc_len,
    output logic             proto_err
);

    localparam logic [3:0] ST_SYNC   = 4'd0;
    localparam logic [3:0] ST_IDLE   = 4'd1;
    localparam logic [3:0] ST_MPEND  = 4'd2;
    localparam logic [3:0] ST_MRD    = 4'd3;
    localparam logic [3:0] ST_MWR    = 4'd4;
    localparam logic [3:0] ST_RFSH   = 4'd5;
    localparam logic [3:0] ST_IORD   = 4'd6;
    localparam logic [3:0] ST_INTACK = 4'd7;
    localparam logic [3:0] ST_IOQ    = 4'd8;
    localparam logic [3:0] ST_IOHOLD = 4'd9;
    localparam logic [3:0] ST_ERR    = 4'd10;

    localparam logic [3:0] FILT = 4'(FILTER_CYCLES);

    logic       s_mreq_b, s_iorq_b, s_rd_b, s_wr_b, s_m1_b, s_rfsh_b;
    logic       s_adr15, s_adr8;
    logic [7:0] s_data;
    // Low until one sample has been taken after reset, so SYNC never trusts the reset values of s_*.
    logic       smp_ok;

    logic [3:0] state, state_nxt;
    logic [3:0] qual_cnt, cnt_nxt, cnt_inc;
    logic       qualify, set_err, bus_idle, io_wr;
    logic       pend_ram, pend_rom;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = qual_cnt;
        cnt_inc   = qual_cnt + 4'd1;
        qualify   = 1'b0;
        set_err   = 1'b0;
        bus_idle  = s_mreq_b & s_iorq_b;
        io_wr     = !s_iorq_b && !s_wr_b;
        case (state)
            ST_SYNC: begin
                if (smp_ok && bus_idle) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (!s_mreq_b && !s_iorq_b) begin
                    state_nxt = ST_ERR;
                    set_err   = 1'b1;
                end else if (!s_mreq_b) begin
                    if (!s_rfsh_b)    state_nxt = ST_RFSH;
                    else if (!s_rd_b) state_nxt = ST_MRD;
                    else if (!s_wr_b) state_nxt = ST_MWR;
                    else              state_nxt = ST_MPEND;
                end else if (!s_iorq_b) begin
                    if (!s_m1_b) begin
                        state_nxt = ST_INTACK;
                    end else if (!s_wr_b) begin
                        cnt_nxt = 4'd1;
                        if (FILT <= 4'd1) begin
                            qualify   = 1'b1;
                            state_nxt = ST_IOHOLD;
                        end else begin
                            state_nxt = ST_IOQ;
                        end
                    end else if (!s_rd_b) begin
                        state_nxt = ST_IORD;
                    end
                end
            end
            ST_MPEND: begin
                if (s_mreq_b)     state_nxt = ST_IDLE;
                else if (!s_rd_b) state_nxt = ST_MRD;
                else if (!s_wr_b) state_nxt = ST_MWR;
            end
            ST_IOQ: begin
                if (io_wr) begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == FILT) begin
                        qualify   = 1'b1;
                        state_nxt = ST_IOHOLD;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_MRD, ST_MWR, ST_RFSH, ST_IORD, ST_INTACK, ST_IOHOLD, ST_ERR: begin
                if (bus_idle) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_mreq_b   <= 1'b1;
            s_iorq_b   <= 1'b1;
            s_rd_b     <= 1'b1;
            s_wr_b     <= 1'b1;
            s_m1_b     <= 1'b1;
            s_rfsh_b   <= 1'b1;
            s_adr15    <= 1'b0;
            s_adr8     <= 1'b0;
            s_data     <= 8'h00;
            smp_ok     <= 1'b0;
            state      <= ST_SYNC;
            qual_cnt   <= 4'd0;
            pend_ram   <= 1'b0;
            pend_rom   <= 1'b0;
            ram_cfg_we <= 1'b0;
            rom_cfg_we <= 1'b0;
            cfg_data   <= 8'h00;
            cfg_lo     <= 1'b0;
            mem_rd_cyc <= 1'b0;
            mem_wr_cyc <= 1'b0;
            cyc_len    <= '0;
            proto_err  <= 1'b0;
        end else begin
            s_mreq_b   <= mreq_b;
            s_iorq_b   <= iorq_b;
            s_rd_b     <= rd_b;
            s_wr_b     <= wr_b;
            s_m1_b     <= m1_b;
            s_rfsh_b   <= rfsh_b;
            s_adr15    <= adr15;
            s_adr8     <= adr8;
            s_data     <= data;
            smp_ok     <= 1'b1;
            state      <= state_nxt;
            qual_cnt   <= cnt_nxt;
            // Decode is latched with the capture; the strobe itself fires one clk later from IOHOLD.
            if (qualify) begin
                cfg_data <= s_data;
                cfg_lo   <= !s_adr8;
                pend_ram <= !s_adr15 && (s_data[7:6] == 2'b11);
                pend_rom <= !s_adr15 && (s_data[7:6] == 2'b10);
            end else begin
                pend_ram <= 1'b0;
                pend_rom <= 1'b0;
            end
            ram_cfg_we <= pend_ram;
            rom_cfg_we <= pend_rom;
            mem_rd_cyc <= (state_nxt == ST_MRD);
            mem_wr_cyc <= (state_nxt == ST_MWR);
            if (set_err) proto_err <= 1'b1;
            if (state_nxt == ST_IDLE || state_nxt == ST_SYNC) cyc_len <= '0;
            else if (cyc_len != '1)                           cyc_len <= cyc_len + 1'b1;
        end
    end

endmodule

// File: tb/tb_cpc_bus_cycle_decoder.sv
// Directed bus cycles; expected cfg strobes queued at issue time and matched by a pulse monitor.
module tb_cpc_bus_cycle_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mreq_b = 1'b1, iorq_b = 1'b1, rd_b = 1'b1, wr_b = 1'b1, m1_b = 1'b1, rfsh_b = 1'b1;
    logic       adr15 = 1'b0, adr8 = 1'b0;
    logic [7:0] data = 8'h00;
    logic       mem_rd_cyc, mem_wr_cyc, ram_cfg_we, rom_cfg_we, cfg_lo, proto_err;
    logic [7:0] cfg_data;
    logic [3:0] cyc_len;

    typedef struct packed {
        logic       ram;
        logic       rom;
        logic [7:0] d;
        logic       lo;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    cpc_bus_cycle_decoder #(.FILTER_CYCLES(2), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .mreq_b(mreq_b), .iorq_b(iorq_b), .rd_b(rd_b), .wr_b(wr_b),
        .m1_b(m1_b), .rfsh_b(rfsh_b), .adr15(adr15), .adr8(adr8), .data(data),
        .mem_rd_cyc(mem_rd_cyc), .mem_wr_cyc(mem_wr_cyc), .ram_cfg_we(ram_cfg_we),
        .rom_cfg_we(rom_cfg_we), .cfg_data(cfg_data), .cfg_lo(cfg_lo), .cyc_len(cyc_len),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pulse(input logic ram, input logic rom, input logic [7:0] d, input logic lo);
        exp_t e;
        e.ram = ram;
        e.rom = rom;
        e.d   = d;
        e.lo  = lo;
        q.push_back(e);
    endtask

    task automatic io_write(input logic a15, input logic a8, input logic [7:0] d, input int n);
        adr15  = a15;
        adr8   = a8;
        data   = d;
        iorq_b = 1'b0;
        wr_b   = 1'b0;
        repeat (n) tick();
        iorq_b = 1'b1;
        wr_b   = 1'b1;
        repeat (4) tick();
    endtask

    task automatic bus_release();
        mreq_b = 1'b1; iorq_b = 1'b1; rd_b = 1'b1; wr_b = 1'b1; m1_b = 1'b1; rfsh_b = 1'b1;
        repeat (3) tick();
    endtask

    // Pulse monitor: every strobe cycle must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ram_cfg_we || rom_cfg_we) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse: ram=%0b rom=%0b cfg_data=0x%0h, expected no pulse",
                             ram_cfg_we, rom_cfg_we, cfg_data);
                end else begin
                    e = q.pop_front();
                    check("pulse_ram", int'(ram_cfg_we), int'(e.ram));
                    check("pulse_rom", int'(rom_cfg_we), int'(e.rom));
                    check("pulse_cfg_data", int'(cfg_data), int'(e.d));
                    check("pulse_cfg_lo", int'(cfg_lo), int'(e.lo));
                end
            end
        end
    end

    initial begin
        repeat (2) tick();
        check("rst_mem_rd", int'(mem_rd_cyc), 0);
        check("rst_mem_wr", int'(mem_wr_cyc), 0);
        check("rst_ram_we", int'(ram_cfg_we), 0);
        check("rst_rom_we", int'(rom_cfg_we), 0);
        check("rst_cfg_data", int'(cfg_data), 0);
        check("rst_cfg_lo", int'(cfg_lo), 0);
        check("rst_cyc_len", int'(cyc_len), 0);
        check("rst_proto_err", int'(proto_err), 0);
        reset = 1'b0;
        repeat (3) tick();

        // OUT &7FC6
        expect_pulse(1'b1, 1'b0, 8'hC6, 1'b0);
        io_write(1'b0, 1'b1, 8'hC6, 3);
        check("7fc6_cfg_data", int'(cfg_data), 'hC6);
        check("7fc6_cfg_lo", int'(cfg_lo), 0);
        check("7fc6_seen", q.size(), 0);

        // OUT &7EC4 then &7F86
        expect_pulse(1'b1, 1'b0, 8'hC4, 1'b1);
        io_write(1'b0, 1'b0, 8'hC4, 2);
        check("7ec4_cfg_lo", int'(cfg_lo), 1);
        expect_pulse(1'b0, 1'b1, 8'h86, 1'b0);
        io_write(1'b0, 1'b1, 8'h86, 4);
        check("7f86_cfg_data", int'(cfg_data), 'h86);
        check("7f86_seen", q.size(), 0);

        // One-clk glitch: filtered out, cfg_data held, back to idle
        io_write(1'b0, 1'b1, 8'hC1, 1);
        check("glitch_cfg_data", int'(cfg_data), 'h86);
        check("glitch_idle", int'(cyc_len), 0);

        // Qualified writes that decode to neither strobe
        io_write(1'b1, 1'b1, 8'hC0, 3);
        io_write(1'b0, 1'b1, 8'h45, 3);

        // Interrupt acknowledge
        adr15 = 1'b0; adr8 = 1'b1; data = 8'hFF;
        iorq_b = 1'b0; m1_b = 1'b0;
        repeat (4) tick();
        check("intack_cyc_len", int'(cyc_len), 3);
        bus_release();
        check("intack_idle", int'(cyc_len), 0);

        // Memory write, stretched past counter saturation
        mreq_b = 1'b0;
        repeat (2) tick();
        check("mpend_mem_wr", int'(mem_wr_cyc), 0);
        check("mpend_cyc_len", int'(cyc_len), 1);
        wr_b = 1'b0;
        repeat (2) tick();
        check("mwr_mem_wr", int'(mem_wr_cyc), 1);
        check("mwr_mem_rd", int'(mem_rd_cyc), 0);
        check("mwr_cyc_len", int'(cyc_len), 3);
        repeat (20) tick();
        check("mwr_cyc_len_sat", int'(cyc_len), 15);
        check("mwr_still_wr", int'(mem_wr_cyc), 1);
        bus_release();
        check("mwr_end_mem_wr", int'(mem_wr_cyc), 0);
        check("mwr_end_cyc_len", int'(cyc_len), 0);

        // Memory read
        mreq_b = 1'b0; rd_b = 1'b0;
        repeat (2) tick();
        check("mrd_mem_rd", int'(mem_rd_cyc), 1);
        check("mrd_mem_wr", int'(mem_wr_cyc), 0);
        bus_release();
        check("mrd_end_mem_rd", int'(mem_rd_cyc), 0);

        // Reset mid-IOQ, released with the write still on the bus
        adr15 = 1'b0; adr8 = 1'b1; data = 8'hC7;
        iorq_b = 1'b0; wr_b = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (5) tick();
        check("rst_ioq_sync", int'(cyc_len), 0);
        check("rst_ioq_cfg_data", int'(cfg_data), 0);
        bus_release();
        expect_pulse(1'b1, 1'b0, 8'hD5, 1'b0);
        io_write(1'b0, 1'b1, 8'hD5, 2);
        check("post_rst_seen", q.size(), 0);

        // MREQ and IORQ together
        data = 8'hC0;
        mreq_b = 1'b0; iorq_b = 1'b0; wr_b = 1'b0;
        repeat (3) tick();
        check("err_proto", int'(proto_err), 1);
        check("err_cyc_len", int'(cyc_len), 2);
        bus_release();
        check("err_sticky", int'(proto_err), 1);
        check("err_idle", int'(cyc_len), 0);
        reset = 1'b1;
        tick();
        check("err_cleared", int'(proto_err), 0);
        reset = 1'b0;

        repeat (5) tick();
        check("pending_pulses", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
